// File: rtl/btb_pkg.sv
// Shared types and sizing for the fetch-stage branch target buffer.
package btb_pkg;

    typedef logic [31:0] rv32i_word;

    localparam int unsigned BTB_SETS_DEFAULT = 16;
    localparam int unsigned BTB_WAYS         = 2;
    // Widest tag (SETS=2); smaller configurations store it zero-extended.
    localparam int unsigned BTB_TAG_MAX      = 29;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [31:2]            target;
        logic                   jump;
    } btb_entry_t;

    function automatic logic [BTB_TAG_MAX-1:0] btb_tag(input rv32i_word pc,
                                                        input int unsigned idx_bits);
        return BTB_TAG_MAX'(pc >> (2 + idx_bits));
    endfunction

endpackage

// File: rtl/btb_if.sv
// Fetch lookup, MEM-stage training and statistics signals of the BTB.
interface btb_if;

    btb_pkg::rv32i_word imem_address;
    logic               lookup_valid;
    logic               br_predicted;
    logic               btb_hit;
    btb_pkg::rv32i_word btb_target;
    btb_pkg::rv32i_word next_pc;
    logic               pred_taken;
    logic               update;
    btb_pkg::rv32i_word mem_pc;
    logic               mem_taken;
    logic               mem_is_jump;
    btb_pkg::rv32i_word mem_target;
    btb_pkg::rv32i_word hit_count;
    btb_pkg::rv32i_word alloc_count;

    modport master (
        output imem_address, lookup_valid, br_predicted,
        output update, mem_pc, mem_taken, mem_is_jump, mem_target,
        input  btb_hit, btb_target, next_pc, pred_taken, hit_count, alloc_count
    );

    modport slave (
        input  imem_address, lookup_valid, br_predicted,
        input  update, mem_pc, mem_taken, mem_is_jump, mem_target,
        output btb_hit, btb_target, next_pc, pred_taken, hit_count, alloc_count
    );

endinterface

// File: rtl/btb_set.sv
// One BTB set: two entries plus an LRU bit; combinational match, registered training.
module btb_set
    import btb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BTB_TAG_MAX-1:0] lookup_tag,
    output logic                   hit,
    output logic [31:2]            hit_target,
    output logic                   hit_jump,
    input  logic                   upd_en,
    input  logic [BTB_TAG_MAX-1:0] upd_tag,
    input  logic                   upd_taken,
    input  logic                   upd_jump,
    input  logic [31:2]            upd_target,
    output logic                   alloc
);

    btb_entry_t            entry [BTB_WAYS];
    logic                  lru;
    logic [BTB_WAYS-1:0]   look_match;
    logic [BTB_WAYS-1:0]   upd_match;
    logic                  hit_way;
    logic                  upd_way;
    logic                  victim;

    always_comb begin
        look_match = '0;
        upd_match  = '0;
        for (int unsigned w = 0; w < BTB_WAYS; w++) begin
            look_match[w] = entry[w].valid && (entry[w].tag == lookup_tag);
            upd_match[w]  = entry[w].valid && (entry[w].tag == upd_tag);
        end
        // Way 0 wins on a double match.
        hit_way    = !look_match[0];
        hit        = |look_match;
        hit_target = entry[hit_way].target;
        hit_jump   = entry[hit_way].jump;
        upd_way    = !upd_match[0];
        victim     = !entry[0].valid ? 1'b0 : (!entry[1].valid ? 1'b1 : lru);
        alloc      = upd_en && upd_taken && !(|upd_match);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lru <= 1'b0;
            for (int unsigned w = 0; w < BTB_WAYS; w++) begin
                entry[w].valid <= 1'b0;
            end
        end else if (upd_en) begin
            if (|upd_match) begin
                if (upd_taken) begin
                    entry[upd_way].target <= upd_target;
                    entry[upd_way].jump   <= upd_jump;
                end
                lru <= ~upd_way;
            end else if (upd_taken) begin
                entry[victim] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, jump: upd_jump};
                lru           <= ~victim;
            end
        end
    end

endmodule

// File: rtl/btb.sv
// Branch target buffer: set index decode, next-PC selection and hit/alloc counters.
module btb
    import btb_pkg::*;
#(
    parameter int unsigned SETS = BTB_SETS_DEFAULT
)(
    input logic  clk,
    input logic  rst,
    btb_if.slave bus
);

    localparam int unsigned IDX = $clog2(SETS);

    logic [IDX-1:0]         look_idx;
    logic [IDX-1:0]         upd_idx;
    logic [BTB_TAG_MAX-1:0] look_tag;
    logic [BTB_TAG_MAX-1:0] upd_tag;
    logic [31:2]            upd_target;

    logic        set_hit    [SETS];
    logic [31:2] set_target [SETS];
    logic        set_jump   [SETS];
    logic        set_alloc  [SETS];

    logic      hit;
    logic      taken;
    rv32i_word target;
    rv32i_word hit_count;
    rv32i_word alloc_count;

    assign look_idx   = bus.imem_address[IDX+1:2];
    assign upd_idx    = bus.mem_pc[IDX+1:2];
    assign look_tag   = btb_tag(bus.imem_address, IDX);
    assign upd_tag    = btb_tag(bus.mem_pc, IDX);
    assign upd_target = 30'(bus.mem_target >> 2);

    for (genvar s = 0; s < SETS; s++) begin : g_set
        btb_set u_set (
            .clk        (clk),
            .rst        (rst),
            .lookup_tag (look_tag),
            .hit        (set_hit[s]),
            .hit_target (set_target[s]),
            .hit_jump   (set_jump[s]),
            .upd_en     (bus.update && (upd_idx == IDX'(s))),
            .upd_tag    (upd_tag),
            .upd_taken  (bus.mem_taken),
            .upd_jump   (bus.mem_is_jump),
            .upd_target (upd_target),
            .alloc      (set_alloc[s])
        );
    end

    always_comb begin
        hit    = set_hit[look_idx];
        target = hit ? {set_target[look_idx], 2'b00} : '0;
        taken  = hit && (bus.br_predicted || set_jump[look_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count   <= '0;
            alloc_count <= '0;
        end else begin
            if (bus.lookup_valid && hit) hit_count <= hit_count + 32'd1;
            if (set_alloc[upd_idx])      alloc_count <= alloc_count + 32'd1;
        end
    end

    assign bus.btb_hit     = hit;
    assign bus.btb_target  = target;
    assign bus.pred_taken  = taken;
    assign bus.next_pc     = taken ? target : bus.imem_address + 32'd4;
    assign bus.hit_count   = hit_count;
    assign bus.alloc_count = alloc_count;

endmodule
